tlu_ch_event_fifo: RTL and testbench

TLU_CH_EVENT_FIFO -- requirements
Module: tlu_ch_event_fifo

---
 rtl/tlu_ch_event_fif_if.sv | 9 +
 rtl/tlu_ch_event_fifo.sv | 123 ++++++++++++
 tb/tb_tlu_ch_event_fifo.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tlu_ch_event_fif_if.sv
// Event read-out stream of tlu_ch_event_fifo: first-word-fall-through data with valid/ready.
interface tlu_ch_event_fifo_if;
    logic [31:0] DOUT;
    logic        DOUT_VALID;
    logic        DOUT_READY;

    modport master (output DOUT, output DOUT_VALID, input DOUT_READY);
    modport slave  (input DOUT, input DOUT_VALID, output DOUT_READY);
endinterface

// File: rtl/tlu_ch_event_fifo.sv
// Rising edges of a channel hit become 32-bit event words in a first-word-fall-through FIFO.
// Define TLU_CH_EVENT_HOLDOFF_EN to ignore hits for HOLDOFF cycles after each accepted event.
module tlu_ch_event_fifo #(
    parameter int DEPTH   = 16,
    parameter int HOLDOFF = 8
) (
    input  logic                CLK40,
    input  logic                RST_N,
    input  logic                EN,
    input  logic                CLR,
    input  logic                VALID,
    input  logic [15:0]         LAST_TOT,
    input  logic [15:0]         LAST_RISING_REL,
    tlu_ch_event_fifo_if.master ev,
    output logic [8:0]          FIFO_CNT,
    output logic [7:0]          LOST_CNT
);
    localparam int         AW        = $clog2(DEPTH);
    localparam logic [8:0] DEPTH_CNT = 9'(DEPTH);

    generate
        if (DEPTH < 4 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 || HOLDOFF < 1) begin : g_param_check
            $error("tlu_ch_event_fifo: DEPTH must be a power of 2 in 4..256 and HOLDOFF >= 1");
        end
    endgenerate

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [8:0]    fifo_cnt;
    logic [7:0]    evt_cnt;
    logic [7:0]    lost_cnt;
    logic          valid_d;

    logic          hit;
    logic          holdoff_active;
    logic          push_req;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    logic [7:0]    tot8;

    always_comb begin
        hit      = VALID & ~valid_d;
        full     = (fifo_cnt == DEPTH_CNT);
        pop      = ev.DOUT_VALID & ev.DOUT_READY;
        push_req = hit & EN & ~CLR & ~holdoff_active;
        // A full FIFO still accepts a push when the oldest word leaves on the same edge.
        push     = push_req & (~full | pop);
        drop     = push_req & full & ~pop;
        tot8     = (LAST_TOT < 16'd255) ? LAST_TOT[7:0] : 8'hFF;
    end

    assign ev.DOUT       = mem[rd_ptr];
    assign ev.DOUT_VALID = (fifo_cnt != 9'd0);
    assign FIFO_CNT      = fifo_cnt;
    assign LOST_CNT      = lost_cnt;

`ifdef TLU_CH_EVENT_HOLDOFF_EN
    localparam int HW = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);

    logic [HW-1:0] holdoff_cnt;

    assign holdoff_active = (holdoff_cnt != '0);

    always_ff @(posedge CLK40 or negedge RST_N) begin
        if (!RST_N) begin
            holdoff_cnt <= '0;
        end else if (CLR) begin
            holdoff_cnt <= '0;
        end else if (push) begin
            holdoff_cnt <= HW'(HOLDOFF);
        end else if (holdoff_active) begin
            holdoff_cnt <= holdoff_cnt - HW'(1);
        end
    end
`else
    assign holdoff_active = 1'b0;
`endif

    always_ff @(posedge CLK40) begin
        if (push) begin
            mem[wr_ptr] <= {evt_cnt, tot8, LAST_RISING_REL};
        end
    end

    always_ff @(posedge CLK40 or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            evt_cnt  <= '0;
            lost_cnt <= '0;
            valid_d  <= 1'b0;
        end else begin
            valid_d <= VALID;
            if (CLR) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
                evt_cnt  <= '0;
                lost_cnt <= '0;
            end else begin
                if (push) begin
                    wr_ptr  <= wr_ptr + AW'(1);
                    evt_cnt <= evt_cnt + 8'd1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (drop && lost_cnt != 8'hFF) begin
                    lost_cnt <= lost_cnt + 8'd1;
                end
                case ({push, pop})
                    2'b10:   fifo_cnt <= fifo_cnt + 9'd1;
                    2'b01:   fifo_cnt <= fifo_cnt - 9'd1;
                    default: fifo_cnt <= fifo_cnt;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tlu_ch_event_fifo.sv
// Scoreboard bench for tlu_ch_event_fifo: queue-based reference model, negedge monitor, directed plus random stimulus.
module tb_tlu_ch_event_fifo;
    localparam int DEPTH   = 16;
    localparam int HOLDOFF = 8;

    logic        CLK40 = 1'b0;
    logic        RST_N = 1'b0;
    logic        EN = 1'b0;
    logic        CLR = 1'b0;
    logic        VALID = 1'b0;
    logic [15:0] LAST_TOT = '0;
    logic [15:0] LAST_RISING_REL = '0;
    logic [8:0]  FIFO_CNT;
    logic [7:0]  LOST_CNT;

    tlu_ch_event_fifo_if ev_if ();

    tlu_ch_event_fifo #(.DEPTH(DEPTH), .HOLDOFF(HOLDOFF)) dut (
        .CLK40           (CLK40),
        .RST_N           (RST_N),
        .EN              (EN),
        .CLR             (CLR),
        .VALID           (VALID),
        .LAST_TOT        (LAST_TOT),
        .LAST_RISING_REL (LAST_RISING_REL),
        .ev              (ev_if.master),
        .FIFO_CNT        (FIFO_CNT),
        .LOST_CNT        (LOST_CNT)
    );

    always #5 CLK40 = ~CLK40;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic logic [7:0] sat8(int t);
        return (t >= 255) ? 8'hFF : 8'(t);
    endfunction

    // Reference model: expected words in order, plus stored-word and lost-event counts.
    logic [31:0] exp_q[$];
    int          m_cnt = 0;
    int          m_lost = 0;
    int          m_evt = 0;
    int          m_hold = 0;
    bit          m_valid_d = 0;
    bit          m_accept;
    bit          m_pop;
    bit          m_pushed;

    always @(posedge CLK40 or negedge RST_N) begin
        if (!RST_N) begin
            exp_q.delete();
            m_cnt = 0; m_lost = 0; m_evt = 0; m_hold = 0; m_valid_d = 0;
        end else begin
            m_accept  = VALID && !m_valid_d && EN;
            m_pop     = (m_cnt > 0) && ev_if.DOUT_READY;
            m_valid_d = VALID;
            m_pushed  = 0;
            if (CLR) begin
                exp_q.delete();
                m_cnt = 0; m_lost = 0; m_evt = 0; m_hold = 0;
            end else begin
`ifdef TLU_CH_EVENT_HOLDOFF_EN
                if (m_hold > 0) begin
                    m_accept = 0;
                    m_hold--;
                end
`endif
                if (m_accept) begin
                    if (m_cnt < DEPTH || m_pop) begin
                        exp_q.push_back({8'(m_evt), sat8(int'(LAST_TOT)), LAST_RISING_REL});
                        m_evt    = (m_evt + 1) % 256;
                        m_pushed = 1;
                        m_hold   = HOLDOFF;
                    end else if (m_lost < 255) begin
                        m_lost++;
                    end
                end
                m_cnt = m_cnt + (m_pushed ? 1 : 0) - (m_pop ? 1 : 0);
            end
        end
    end

    int          pop_count = 0;
    logic [31:0] last_pop = '0;

    always @(negedge CLK40) begin
        if (RST_N) begin
            chk("dout_valid", 32'(ev_if.DOUT_VALID), 32'(m_cnt != 0));
            chk("fifo_cnt", 32'(FIFO_CNT), 32'(m_cnt));
            chk("lost_cnt", 32'(LOST_CNT), 32'(m_lost));
            if (ev_if.DOUT_VALID) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL dout_unexpected: got %h expected no word", ev_if.DOUT);
                end else begin
                    chk("dout_word", ev_if.DOUT, exp_q[0]);
                    if (ev_if.DOUT_READY) begin
                        last_pop = ev_if.DOUT;
                        pop_count++;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge CLK40);
        #1;
    endtask

    task automatic pulse();
        VALID = 1'b1; cyc();
        VALID = 1'b0; cyc();
    endtask

    task automatic do_clr();
        CLR = 1'b1; cyc();
        CLR = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        ev_if.DOUT_READY = 1'b0;
        repeat (3) @(posedge CLK40);
        #1 RST_N = 1'b1;
        EN = 1'b1;
        chk("reset_fifo_cnt", 32'(FIFO_CNT), 32'd0);
        chk("reset_dout_valid", 32'(ev_if.DOUT_VALID), 32'd0);

        // Single held pulse yields one word, visible one cycle after the rising edge.
        do_clr();
        VALID = 1'b1; LAST_TOT = 16'h0030; LAST_RISING_REL = 16'h0025;
        cyc();
        chk("pulse_word", ev_if.DOUT, 32'h00300025);
        chk("pulse_valid", 32'(ev_if.DOUT_VALID), 32'd1);
        chk("pulse_cnt", 32'(FIFO_CNT), 32'd1);
        repeat (4) cyc();
        chk("pulse_cnt_held", 32'(FIFO_CNT), 32'd1);
        VALID = 1'b0; ev_if.DOUT_READY = 1'b1;
        repeat (3) cyc();
        ev_if.DOUT_READY = 1'b0;

        // Overfill: 20 events into 16 words.
        do_clr();
        for (int i = 0; i < 20; i++) begin
            LAST_TOT = 16'($urandom_range(0, 400));
            LAST_RISING_REL = 16'($urandom);
            pulse();
        end
        chk("full_cnt", 32'(FIFO_CNT), 32'd16);
        chk("full_lost", 32'(LOST_CNT), 32'd4);
        chk("full_head", 32'(ev_if.DOUT[31:24]), 32'd0);

        // Event coincident with a pop on a full FIFO.
        VALID = 1'b1; ev_if.DOUT_READY = 1'b1; cyc();
        VALID = 1'b0; ev_if.DOUT_READY = 1'b0;
        chk("coinc_cnt", 32'(FIFO_CNT), 32'd16);
        chk("coinc_lost", 32'(LOST_CNT), 32'd4);
        chk("coinc_head", 32'(ev_if.DOUT[31:24]), 32'd1);
        ev_if.DOUT_READY = 1'b1;
        repeat (20) cyc();
        chk("coinc_last", 32'(last_pop[31:24]), 32'd16);
        chk("drained_cnt", 32'(FIFO_CNT), 32'd0);

        // ToT saturation and event-counter wrap over 257 words.
        do_clr();
        LAST_TOT = 16'h0123;
        base = pop_count;
        for (int i = 0; i < 257; i++) begin
            LAST_RISING_REL = 16'($urandom);
            pulse();
        end
        repeat (3) cyc();
        chk("wrap_pops", 32'(pop_count - base), 32'd257);
        chk("wrap_evt", 32'(last_pop[31:24]), 32'd0);
        chk("sat_tot", 32'(last_pop[23:16]), 32'hFF);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            VALID = ($urandom_range(0, 2) == 0);
            EN = ($urandom_range(0, 9) != 0);
            CLR = ($urandom_range(0, 149) == 0);
            ev_if.DOUT_READY = ($urandom_range(0, 3) == 0);
            LAST_TOT = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(240, 270)) : 16'($urandom);
            LAST_RISING_REL = 16'($urandom);
            cyc();
        end
        VALID = 1'b0; EN = 1'b1; CLR = 1'b0; ev_if.DOUT_READY = 1'b0;
        cyc();

        // Asynchronous reset with 7 words stored.
        do_clr();
        for (int i = 0; i < 7; i++) pulse();
        chk("pre_reset_cnt", 32'(FIFO_CNT), 32'd7);
        @(negedge CLK40);
        #2 RST_N = 1'b0;
        #1;
        chk("async_dout_valid", 32'(ev_if.DOUT_VALID), 32'd0);
        chk("async_fifo_cnt", 32'(FIFO_CNT), 32'd0);
        chk("async_lost", 32'(LOST_CNT), 32'd0);
        VALID = 1'b1;
        @(negedge CLK40);
        #2 RST_N = 1'b1;
        @(posedge CLK40);
        #1;
        chk("post_reset_cnt", 32'(FIFO_CNT), 32'd1);
        chk("post_reset_evt", 32'(ev_if.DOUT[31:24]), 32'd0);
        VALID = 1'b0; ev_if.DOUT_READY = 1'b1;
        repeat (3) cyc();

        // Events every 3 cycles: holdoff thins them when enabled.
        do_clr();
        base = pop_count;
        for (int i = 0; i < 12; i++) begin
            VALID = 1'b1; cyc();
            VALID = 1'b0; cyc(); cyc();
        end
        repeat (3) cyc();
`ifdef TLU_CH_EVENT_HOLDOFF_EN
        chk("holdoff_accepted", 32'(pop_count - base), 32'd4);
`else
        chk("holdoff_accepted", 32'(pop_count - base), 32'd12);
`endif
        chk("holdoff_lost", 32'(LOST_CNT), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
